// File: rtl/fifo_umbral_ctrl.sv
// Synchronous data FIFO with programmable almost-full/almost-empty thresholds
// and a sticky overflow/underflow error flag for the channel control FSM.
module fifo_umbral_ctrl #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              load_umb,
  input  logic [AW:0]       umbral_alto,
  input  logic [AW:0]       umbral_bajo,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_error,
  output logic [AW:0]       count
);

  localparam logic [AW:0]       CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]       CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]       ALTO_RST = (AW+1)'(DEPTH-1);
  localparam logic [AW-1:0]     PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [AW:0]       alto_q, alto_d;
  logic [AW:0]       bajo_q, bajo_d;

  logic wr_ok_s;
  logic rd_ok_s;
  logic err_evt_s;

  // Occupancy count (0..DEPTH) separates full from empty at any pointer wrap.
  always_comb begin
    wr_ok_s   = wr_en & ((count_q != CNT_FULL) | rd_en);
    rd_ok_s   = rd_en & (count_q != CNT_ZERO);
    err_evt_s = (wr_en & ~rd_en & (count_q == CNT_FULL)) |
                (rd_en & (count_q == CNT_ZERO));

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q | err_evt_s;
    alto_d     = alto_q;
    bajo_d     = bajo_q;

    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_ok_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (load_umb) begin
      alto_d = umbral_alto;
      bajo_d = umbral_bajo;
    end else begin
      alto_d = alto_q;
      bajo_d = bajo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      data_out_q <= DATA_ZERO;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      alto_q     <= ALTO_RST;
      bajo_q     <= CNT_ONE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
    end
  end

  // Storage is deliberately left uninitialised; reset only clears pointers.
  always_ff @(posedge clk) begin
    if (reset && wr_ok_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign fifo_error   = error_q;
  assign count        = count_q;
  assign fifo_full    = (count_q == CNT_FULL);
  assign fifo_empty   = (count_q == CNT_ZERO);
  assign almost_full  = (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);

endmodule

// File: tb/tb_fifo_umbral_ctrl.sv
// Directed bench for fifo_umbral_ctrl: a vector table for the basic fill/drain
// pass plus hand-written sequences for overflow, underflow, thresholds and wrap.
module tb_fifo_umbral_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [5:0] data_in;
  logic       rd_en;
  logic [5:0] data_out;
  logic       valid_out;
  logic       load_umb;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       fifo_full, fifo_empty, almost_full, almost_empty, fifo_error;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  fifo_umbral_ctrl #(.DATA_W(6), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .valid_out(valid_out), .load_umb(load_umb),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_error(fifo_error), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [5:0]  din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [20];

  // Packed view: {count, full, empty, afull, aempty, err, valid, dout}
  function automatic logic [15:0] pk(input int c, input bit f, input bit e,
                                     input bit af, input bit ae, input bit er,
                                     input bit v, input int d);
    logic [3:0] c4;
    logic [5:0] d6;
    c4 = c[3:0];
    d6 = d[5:0];
    return {c4, f, e, af, ae, er, v, d6};
  endfunction

  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [5:0] din, input logic ld,
                      input logic [3:0] alto, input logic [3:0] bajo);
    reset = rst; wr_en = wr; rd_en = rd; data_in = din;
    load_umb = ld; umbral_alto = alto; umbral_bajo = bajo;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {count, fifo_full, fifo_empty, almost_full, almost_empty,
           fifo_error, valid_out, data_out};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 6'd0;
    load_umb = 1'b0; umbral_alto = 4'd0; umbral_bajo = 4'd0;
    #2;

    // reset, two idle cycles, 8 writes 0x01..0x08, 8 reads, one idle
    tbl[0] = '{1'b0, 1'b0, 1'b0, 6'd0, pk(0, 0, 1, 0, 1, 0, 0, 0)};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 6'd0, pk(0, 0, 1, 0, 1, 0, 0, 0)};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 6'd0, pk(0, 0, 1, 0, 1, 0, 0, 0)};
    for (int k = 1; k <= 8; k++)
      tbl[2+k] = '{1'b1, 1'b1, 1'b0, 6'(k),
                   pk(k, k == 8, 0, k >= 7, k <= 1, 0, 0, 0)};
    for (int r = 1; r <= 8; r++)
      tbl[10+r] = '{1'b1, 1'b0, 1'b1, 6'd0,
                    pk(8 - r, 0, r == 8, r == 1, r >= 7, 0, 1, r)};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 6'd0, pk(0, 0, 1, 0, 1, 0, 0, 8)};

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din, 1'b0, 4'd0, 4'd0);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Overflow: 9th write dropped, error sticky until reset
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, 6'(k), 1'b0, 4'd0, 4'd0);
    chk("ovf_full", pk(8, 1, 0, 1, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b0, 6'h3F, 1'b0, 4'd0, 4'd0);
    chk("ovf_err", pk(8, 1, 0, 1, 0, 1, 0, 0));
    for (int r = 1; r <= 8; r++) begin
      step(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 4'd0, 4'd0);
      chk($sformatf("ovf_drain%0d", r),
          pk(8 - r, 0, r == 8, r == 1, r >= 7, 1, 1, r));
    end
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    chk("ovf_sticky", pk(0, 0, 1, 0, 1, 1, 0, 8));
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    chk("ovf_clear", pk(0, 0, 1, 0, 1, 0, 0, 0));

    // Empty with simultaneous read and write: no bypass, underflow error
    step(1'b1, 1'b1, 1'b1, 6'h15, 1'b0, 4'd0, 4'd0);
    chk("udf_rw", pk(1, 0, 0, 0, 1, 1, 0, 0));
    step(1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 4'd0, 4'd0);
    chk("udf_read", pk(0, 0, 1, 0, 1, 1, 1, 6'h15));

    // Thresholds alto=5 bajo=2, then 5 writes
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 4'd5, 4'd2);
    chk("thr_load", pk(0, 0, 1, 0, 1, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 6'(k), 1'b0, 4'd0, 4'd0);
      chk($sformatf("thr_w%0d", k), pk(k, 0, 0, k >= 5, k <= 2, 0, 0, 0));
    end
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 4'd0, 4'd0);
    chk("thr_alto0", pk(5, 0, 0, 1, 0, 0, 0, 0));

    // Full with 20 cycles of simultaneous read/write across pointer wrap
    step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 6'(k), 1'b0, 4'd0, 4'd0);
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 1'b1, 1'b1, 6'(8 + j), 1'b0, 4'd0, 4'd0);
      chk($sformatf("wrap%0d", j), pk(8, 1, 0, 1, 0, 0, 1, j));
    end
    step(1'b0, 1'b1, 1'b1, 6'd40, 1'b0, 4'd0, 4'd0);
    chk("mid_reset", pk(0, 0, 1, 0, 1, 0, 0, 0));
    step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0, 4'd0);
    chk("post_reset", pk(0, 0, 1, 0, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
